// File: rtl/inst_rom_pipe_if.sv
// Fetch/response/load bus between the fetch stage and the instruction ROM.
// The ROM sits on the slave side. The fetch stage, boot loader or bench sits on the master side.
interface inst_rom_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              init_done;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ack;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic              rsp_err;

    modport master (
        output load_en, load_addr, load_data, fetch_valid, fetch_addr, rsp_ready,
        input  init_done, load_ack, fetch_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  load_en, load_addr, load_data, fetch_valid, fetch_addr, rsp_ready,
        output init_done, load_ack, fetch_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/inst_rom_pipe.sv
// Word-addressed instruction memory.
// - After reset, a hardware sequence clears every word to NOP_WORD.
// - A runtime load port writes the program into memory.
// - Fetches pass through a READ_LAT-deep pipeline (legal range 1..3) with
//   valid/ready backpressure on the response side.
// - Misaligned or out-of-range addresses are flagged as errors:
//   an error fetch returns NOP_WORD with rsp_err set, and an error load is dropped.
module inst_rom_pipe #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH_LOG2 = 8,
    parameter int                 READ_LAT   = 1,
    parameter logic [DATA_W-1:0]  NOP_WORD   = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_rom_pipe_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // An address is bad if it is not word aligned or lies above the last word.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:DEPTH_LOG2+2] != '0);
    endfunction

    state_t                             state_q, state_d;
    logic [DEPTH_LOG2-1:0]              clr_cnt_q, clr_cnt_d;
    logic                               load_ack_q, load_ack_d;
    logic [READ_LAT-1:0]                vld_q, vld_d;
    logic [READ_LAT-1:0][DATA_W-1:0]    inst_q, inst_d;
    logic [READ_LAT-1:0]                err_q, err_d;
    logic [DATA_W-1:0]                  mem_q [DEPTH];

    logic                               running;
    logic                               advance;
    logic                               fetch_acc;
    logic                               load_acc;
    logic                               mem_we;
    logic [DEPTH_LOG2-1:0]              mem_waddr;
    logic [DATA_W-1:0]                  mem_wdata;
    logic [DEPTH_LOG2-1:0]              fetch_idx;

    assign running   = (state_q == ST_RUN);
    assign advance   = !vld_q[READ_LAT-1] || bus.rsp_ready;
    assign fetch_acc = bus.fetch_valid && running && advance;
    assign load_acc  = bus.load_en && running && !addr_bad(bus.load_addr);
    assign fetch_idx = bus.fetch_addr[DEPTH_LOG2+1:2];

    assign bus.init_done   = running;
    assign bus.fetch_ready = running && advance;
    assign bus.load_ack    = load_ack_q;
    assign bus.rsp_valid   = vld_q[READ_LAT-1];
    assign bus.rsp_inst    = inst_q[READ_LAT-1];
    assign bus.rsp_err     = err_q[READ_LAT-1];

    // Clear sequence: walk every entry once, then run until the next reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {DEPTH_LOG2{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Memory write source: the clear walker owns the write port until running, then the load port owns it.
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt_q;
        mem_wdata  = NOP_WORD;
        load_ack_d = load_acc;
        if (!running) begin
            mem_we = 1'b1;
        end else if (load_acc) begin
            mem_we    = 1'b1;
            mem_waddr = bus.load_addr[DEPTH_LOG2+1:2];
            mem_wdata = bus.load_data;
        end
    end

    // Fetch pipeline: stage 0 is the memory read register.
    // The whole pipeline moves together or freezes together.
    always_comb begin
        vld_d  = vld_q;
        inst_d = inst_q;
        err_d  = err_q;
        if (advance) begin
            for (int i = READ_LAT - 1; i > 0; i--) begin
                vld_d[i]  = vld_q[i-1];
                inst_d[i] = inst_q[i-1];
                err_d[i]  = err_q[i-1];
            end
            vld_d[0]  = fetch_acc;
            inst_d[0] = NOP_WORD;
            err_d[0]  = 1'b0;
            if (fetch_acc) begin
                if (addr_bad(bus.fetch_addr)) begin
                    err_d[0] = 1'b1;
                end else begin
                    inst_d[0] = mem_q[fetch_idx];
                end
            end
        end
    end

    // Control and pipeline registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            load_ack_q <= 1'b0;
            vld_q      <= '0;
            inst_q     <= {READ_LAT{NOP_WORD}};
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            load_ack_q <= load_ack_d;
            vld_q      <= vld_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
        end
    end

    // Memory array.
    // - It has no reset; the clear sequence initialises it.
    // - The read in the same cycle sees the old word, so reads come before writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_inst_rom_pipe.sv
// Randomised scoreboard bench for inst_rom_pipe (READ_LAT=2).
// A negedge monitor keeps a word-array model of the ROM.
// It queues expected responses at each accepted fetch and checks them as the DUT presents them.
module tb_inst_rom_pipe;
    localparam int          READ_LAT = 2;
    localparam int          DEPTH    = 256;
    localparam logic [31:0] NOP      = 32'h00000000;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          adv_cnt = 0;
    logic        exp_ack = 1'b0;
    logic        exp_valid;
    logic        init_exp;
    logic        adv;
    exp_t        e;

    inst_rom_pipe_if #(.ADDR_W(32), .DATA_W(32)) rom_if ();

    inst_rom_pipe #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .READ_LAT(READ_LAT), .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(rom_if)
    );

    always #5 clk = ~clk;

    // Address rule from the ROM's point of view: word aligned and inside 256 words.
    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH * 4);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic le,
                                 input logic [31:0] la, input logic [31:0] ld, input logic rr);
        rom_if.fetch_valid = fv;
        rom_if.fetch_addr  = fa;
        rom_if.load_en     = le;
        rom_if.load_addr   = la;
        rom_if.load_data   = ld;
        rom_if.rsp_ready   = rr;
        @(posedge clk);
        #1;
    endtask

    // Monitor and reference model, evaluated half a cycle before each rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_rsp_valid", rom_if.rsp_valid, 0);
            checkOutput("rst_init_done", rom_if.init_done, 0);
            checkOutput("rst_load_ack", rom_if.load_ack, 0);
            checkOutput("rst_fetch_ready", rom_if.fetch_ready, 0);
            checkOutput("rst_rsp_inst", rom_if.rsp_inst, NOP);
            checkOutput("rst_rsp_err", rom_if.rsp_err, 0);
            sb_q.delete();
            for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
            cyc = 0;
            adv_cnt = 0;
            exp_ack = 1'b0;
        end else begin
            init_exp = (cyc >= DEPTH);
            checkOutput("init_done", rom_if.init_done, init_exp);
            checkOutput("load_ack", rom_if.load_ack, exp_ack);
            exp_valid = (sb_q.size() > 0) && (adv_cnt - sb_q[0].acc >= READ_LAT);
            checkOutput("rsp_valid", rom_if.rsp_valid, exp_valid);
            if (exp_valid && rom_if.rsp_valid) begin
                checkOutput("rsp_inst", rom_if.rsp_inst, sb_q[0].inst);
                checkOutput("rsp_err", rom_if.rsp_err, sb_q[0].err);
            end
            adv = !exp_valid || rom_if.rsp_ready;
            checkOutput("fetch_ready", rom_if.fetch_ready, init_exp && adv);
            if (exp_valid && rom_if.rsp_ready) void'(sb_q.pop_front());
            if (rom_if.fetch_valid && init_exp && adv) begin
                e.err  = bad_addr(rom_if.fetch_addr);
                e.inst = e.err ? NOP : model_mem[rom_if.fetch_addr / 4];
                e.acc  = adv_cnt;
                sb_q.push_back(e);
            end
            exp_ack = init_exp && rom_if.load_en && !bad_addr(rom_if.load_addr);
            if (exp_ack) model_mem[rom_if.load_addr / 4] = rom_if.load_data;
            if (adv) adv_cnt++;
            cyc++;
        end
    end

    initial begin
        rom_if.fetch_valid = 1'b0;
        rom_if.fetch_addr  = '0;
        rom_if.load_en     = 1'b0;
        rom_if.load_addr   = '0;
        rom_if.load_data   = '0;
        rom_if.rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch held during the clear sequence, plus a load that must be dropped.
        for (int i = 0; i < 262; i++) begin
            applyStimulus(1'b1, 32'h0, (i == 10), 32'h8, 32'h12345678, 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Program loads, then back-to-back fetches.
        applyStimulus(1'b0, 0, 1'b1, 32'h04, 32'h00430820, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 32'h10, 32'h3426800a, 1'b1);
        applyStimulus(1'b1, 32'h04, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b1, 32'h08, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b1, 32'h10, 1'b0, 0, 0, 1'b1);
        repeat (4) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Stream with a three-cycle output stall in the middle.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 32'h04 + 32'(4 * (i % 4)), 1'b0, 0, 0, !(i >= 3 && i <= 5));
        end
        repeat (4) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Error fetches, error load, and a readback to confirm the bad load left memory alone.
        applyStimulus(1'b1, 32'h06, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b1, 32'h400, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 32'h402, 32'hdeadbeef, 1'b1);
        applyStimulus(1'b1, 32'h00, 1'b0, 0, 0, 1'b1);
        repeat (4) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Same-cycle load and fetch of one word, then a second fetch of that word.
        applyStimulus(1'b1, 32'h14, 1'b1, 32'h14, 32'h00251a2a, 1'b1);
        applyStimulus(1'b1, 32'h14, 1'b0, 0, 0, 1'b1);
        repeat (4) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Random traffic: loads and fetches colliding on a small window, with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] fa, la;
            fa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 31) * 4);
            la = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 31) * 4);
            applyStimulus($urandom_range(0, 3) != 0, fa, $urandom_range(0, 2) == 0, la, $urandom,
                          $urandom_range(0, 3) != 0);
        end
        repeat (8) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Reset while two fetches are in flight, then re-clear and read back.
        applyStimulus(1'b0, 0, 1'b1, 32'h04, 32'hcafef00d, 1'b1);
        applyStimulus(1'b1, 32'h04, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b1, 32'h08, 1'b0, 0, 0, 1'b1);
        rst_n = 1'b0;
        repeat (2) applyStimulus(1'b0, 0, 1'b1, 32'h0c, 32'h11111111, 1'b1);
        rst_n = 1'b1;
        repeat (258) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b1, 32'h04, 1'b0, 0, 0, 1'b1);
        repeat (6) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);

        checkOutput("drain_empty", 64'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inst_rom_pipe.md
Name: inst_rom_pipe

Overview:
- Parametrised successor to the fixed single-cycle instruction ROM: word-addressed instruction memory with a runtime load port, a hardware clear sequence after reset, configurable read latency, and a valid/ready fetch/response handshake with backpressure.
- Sits between the PC/fetch stage and the decode stage of the CPU.
- A bench or boot path loads the program through the load port instead of using initial blocks.

Parameters:
- ADDR_W, 32, width of fetch and load byte addresses.
- DATA_W, 32, instruction word width.
- DEPTH_LOG2, 8, log2 of word count (256 words).
- READ_LAT, 1, fetch-accept to response latency in cycles; legal range 1..3.
- NOP_WORD, 32'h00000000, clear value and the instruction returned on error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the clear sequence has finished.
- load_en  in  1  write one word this cycle.
- load_addr  in  ADDR_W  byte address of load word.
- load_data  in  DATA_W  word to store.
- load_ack  out  1  registered; high the cycle after a load was accepted.
- fetch_valid  in  1  fetch request valid.
- fetch_ready  out  1  fetch request can be accepted.
- fetch_addr  in  ADDR_W  byte address (PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_inst  out  DATA_W  fetched instruction.
- rsp_err  out  1  fetch address misaligned or out of range.

Behaviour:
- Reset values (asserted asynchronously): init_done=0, load_ack=0, rsp_valid=0, rsp_inst=NOP_WORD, rsp_err=0, all pipeline valid bits 0, FSM=CLEAR, clear counter=0.
- FSM has two states, CLEAR and RUN.
  - CLEAR: writes NOP_WORD to entry counter each cycle and increments the counter. After writing entry 2^DEPTH_LOG2-1, moves to RUN. Clear therefore takes exactly 2^DEPTH_LOG2 cycles after rst_n rises.
  - RUN: init_done=1 and stays in RUN until reset.
- fetch_ready = init_done && (!rsp_valid || rsp_ready). Purely combinational; no dependency on fetch_valid.
- Word index = addr[DEPTH_LOG2+1:2] for both fetch and load.
- Address error when addr[1:0]!=0 or any bit of addr[ADDR_W-1:DEPTH_LOG2+2] is 1.
- Load port:
  - Accepted only in RUN and only when the address has no error.
  - Loads in CLEAR or with an erroneous address are dropped, with load_ack=0 the next cycle.
  - Accepted load writes the memory at the edge; load_ack=1 for one cycle after.
- Fetch pipeline:
  - A fetch is accepted on fetch_valid && fetch_ready.
  - The pipeline is READ_LAT stages and the whole pipeline advances when advance = (!rsp_valid || rsp_ready).
  - When not advancing, every stage, including the memory read register, holds its value.
  - An accepted fetch appears on rsp_* exactly READ_LAT cycles later when no stall occurs. Each stall cycle adds one cycle.
  - Sustained throughput is 1 fetch/cycle with rsp_ready=1.
  - With rsp_ready=0, rsp_valid, rsp_inst and rsp_err are held stable until accepted.
  - An error fetch returns rsp_inst=NOP_WORD and rsp_err=1, with the same latency as a normal fetch.
  - When advancing with no fetch accepted, a bubble enters and rsp_valid falls once the bubble reaches the output.
- Same-cycle load and fetch to the same index: read-before-write, so the fetch returns the old word. A fetch accepted one or more cycles after the load returns the new word.
- Reset asserted mid-operation: in-flight fetches are discarded with no response, any load that cycle is lost, and memory is re-cleared by a new CLEAR sequence.
- Responses are in order; no reordering and no dropping except on reset.

Test Plan:
- Release rst_n, hold fetch_valid=1 with fetch_addr=0 -> fetch_ready=0 and init_done=0 for 256 cycles; init_done=1 on cycle 256; first response is rsp_inst=32'h00000000, rsp_err=0 READ_LAT cycles after accept.
- Load word index 1 = 32'h00430820 (add $1,$2,$3), index 4 = 32'h3426800a (ori); fetch 0x04, 0x08, 0x10 back-to-back with READ_LAT=2 -> responses 32'h00430820, 32'h00000000, 32'h3426800a on consecutive cycles starting 2 cycles after the first accept.
- Fetch stream 0x04..0x10 with rsp_ready held 0 for 3 cycles mid-stream -> fetch_ready=0 while the output is stalled, rsp_inst stable, no response lost or duplicated, order preserved.
- Fetch 0x06 and 0x400 -> rsp_err=1 and rsp_inst=32'h00000000 for both; load to 0x402 -> load_ack=0 and memory unchanged.
- Load index 5 = 32'h00251a2a in the same cycle as a fetch of 0x14 -> that fetch returns 32'h00000000; the next fetch of 0x14 returns 32'h00251a2a.
- Assert rst_n low with 2 fetches in flight -> rsp_valid=0 immediately and no stale responses appear; after re-clear, fetch of 0x04 returns 32'h00000000.
